// File: rtl/hpi_slave_responder.sv
// HPI slave responder: word RAM behind an auto-incrementing byte address, two mailboxes and a status word.
// Each access acts once, in the first cycle its strobe is seen low; read data is driven from the following cycle.
module hpi_slave_responder #(
  parameter int          MEM_AW     = 10,
  parameter logic [15:0] RESET_ADDR = 16'h0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        OTG_RST_N,
  input  logic [1:0]  OTG_ADDR,
  input  logic        OTG_CS_N,
  input  logic        OTG_RD_N,
  input  logic        OTG_WR_N,
  inout  wire  [15:0] OTG_DATA,
  output logic        OTG_INT,
  input  logic        dev_mbox_wr,
  input  logic [15:0] dev_mbox_wdata,
  output logic [15:0] host_mbox_rdata,
  output logic        host_mbox_valid,
  input  logic        dev_mbox_ack
);

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_MAILBOX = 2'd1;
  localparam logic [1:0] REG_ADDRESS = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  logic [15:0] mem [2**MEM_AW];

  logic              rst;
  logic              rd_act, wr_act, rd_act_q, wr_act_q;
  logic              rd_start, wr_start;
  logic [15:0]       addr, rdq, host_mbox, dev_mbox;
  logic              host_mbox_full, dev_mbox_full, ovr;
  logic [MEM_AW-1:0] mem_idx;

  assign rst      = Reset | ~OTG_RST_N;
  assign rd_act   = ~OTG_CS_N & ~OTG_RD_N & OTG_WR_N;
  assign wr_act   = ~OTG_CS_N & ~OTG_WR_N & OTG_RD_N;
  assign rd_start = rd_act & ~rd_act_q;
  assign wr_start = wr_act & ~wr_act_q;
  // Bit 0 is the byte lane; high bits alias onto the RAM.
  assign mem_idx  = addr[MEM_AW:1];

  // Bus released while in reset so a reset mid-read turns the bus around at once.
  assign OTG_DATA        = (rd_act && !rst) ? rdq : 16'bz;
  assign OTG_INT         = dev_mbox_full;
  assign host_mbox_valid = host_mbox_full;
  assign host_mbox_rdata = host_mbox;

  // RAM contents survive reset.
  always_ff @(posedge Clk) begin
    if (!rst && wr_start && OTG_ADDR == REG_DATA)
      mem[mem_idx] <= OTG_DATA;
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      addr           <= RESET_ADDR;
      rdq            <= 16'h0000;
      host_mbox      <= 16'h0000;
      dev_mbox       <= 16'h0000;
      host_mbox_full <= 1'b0;
      dev_mbox_full  <= 1'b0;
      ovr            <= 1'b0;
      rd_act_q       <= 1'b0;
      wr_act_q       <= 1'b0;
    end else begin
      rd_act_q <= rd_act;
      wr_act_q <= wr_act;

      if (dev_mbox_ack)
        host_mbox_full <= 1'b0;

      // Placed after the ack so a simultaneous host write leaves the mailbox full.
      if (wr_start) begin
        case (OTG_ADDR)
          REG_DATA:    addr <= addr + 16'd2;
          REG_MAILBOX: begin
            host_mbox      <= OTG_DATA;
            host_mbox_full <= 1'b1;
            if (host_mbox_full)
              ovr <= 1'b1;
          end
          REG_ADDRESS: addr <= OTG_DATA;
          default:     ;
        endcase
      end

      if (rd_start) begin
        case (OTG_ADDR)
          REG_DATA: begin
            rdq  <= mem[mem_idx];
            addr <= addr + 16'd2;
          end
          REG_MAILBOX: begin
            rdq           <= dev_mbox;
            dev_mbox_full <= 1'b0;
          end
          REG_ADDRESS: rdq <= addr;
          REG_STATUS: begin
            rdq <= {13'b0, ovr, dev_mbox_full, host_mbox_full};
            ovr <= 1'b0;
          end
          default: ;
        endcase
      end

      // A device post overrides a same-cycle host mailbox read clearing the flag.
      if (dev_mbox_wr) begin
        dev_mbox      <= dev_mbox_wdata;
        dev_mbox_full <= 1'b1;
      end
    end
  end

endmodule
